// File: rtl/stage_sequencer.sv
// stage_sequencer: multicycle control unit for the ARM datapath.
// Steps each instruction through IF, RF, EX, MEM and WB with one-hot stage
// enables. Annulled instructions skip from RF straight to WB. Non-memory
// instructions skip MEM. MEM waits on the data-memory ready handshake.
// Retired (non-annulled) instructions are counted.
// Optional feature macro: STAGE_SEQ_MEM_TIMEOUT_EN adds a MEM wait timeout.
// On timeout the instruction is aborted and a sticky mem_fault flag is set.
// Reset (nreset) is synchronous and active-high, despite its name.
module stage_sequencer #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             cond_pass,
    input  logic             is_branch,
    input  logic             is_mem,
    input  logic             is_load,
    input  logic             writes_rd,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic             fetch_go,
    output logic             regfetch_go,
    output logic             execute_go,
    output logic             mem_go,
    output logic             wb_go,
    output logic             mem_enable,
    output logic             mem_read_not_write,
    output logic             reg_write,
    output logic             pc_write,
    output logic             pc_sel_branch,
    output logic [2:0]       state,
    output logic             halted,
    output logic             mem_fault,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_RF   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    // A zero timeout would make the wait counter meaningless
    if (MEM_TIMEOUT < 1) begin : g_bad_timeout
        $error("MEM_TIMEOUT must be at least 1");
    end

    logic [2:0] state_next;
    logic       branch_q;
    logic       mem_q;
    logic       load_q;
    logic       wr_q;
    logic       annul_q;
    logic       abort_q;
    logic       timeout_hit;

`ifdef STAGE_SEQ_MEM_TIMEOUT_EN
    localparam int TO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    logic [TO_W-1:0] wait_cnt;

    // A ready arriving in the limit cycle wins, so only a still-stalled MEM times out
    assign timeout_hit = (state == S_MEM) && !mem_ready && (wait_cnt == TO_LIMIT);

    // Wait counter sits at zero outside MEM and counts stalled MEM cycles
    always_ff @(posedge clk) begin
        if (nreset)
            wait_cnt <= '0;
        else if (state != S_MEM)
            wait_cnt <= '0;
        else if (!mem_ready && !timeout_hit)
            wait_cnt <= wait_cnt + TO_W'(1);
    end

    // Abort marks the in-flight instruction; mem_fault remembers any timeout until reset
    always_ff @(posedge clk) begin
        if (nreset) begin
            abort_q   <= 1'b0;
            mem_fault <= 1'b0;
        end else if (state == S_RF) begin
            abort_q   <= 1'b0;
        end else if (timeout_hit) begin
            abort_q   <= 1'b1;
            mem_fault <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign abort_q     = 1'b0;
    assign mem_fault   = 1'b0;
`endif

    // Next-state selection; unused codes recover to IF
    always_comb begin
        state_next = S_IF;
        case (state)
            S_IF:    state_next = S_RF;
            S_RF:    state_next = cond_pass ? S_EX : S_WB;
            S_EX:    state_next = mem_q ? S_MEM : S_WB;
            S_MEM:   state_next = (mem_ready || timeout_hit) ? S_WB : S_MEM;
            S_WB:    state_next = halt_req ? S_HALT : S_IF;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IF;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (nreset)
            state <= S_IF;
        else
            state <= state_next;
    end

    // Decoded instruction flags are captured once, during RF
    always_ff @(posedge clk) begin
        if (nreset) begin
            branch_q <= 1'b0;
            mem_q    <= 1'b0;
            load_q   <= 1'b0;
            wr_q     <= 1'b0;
            annul_q  <= 1'b0;
        end else if (state == S_RF) begin
            branch_q <= is_branch;
            mem_q    <= is_mem;
            load_q   <= is_load;
            wr_q     <= writes_rd;
            annul_q  <= ~cond_pass;
        end
    end

    // Retired-instruction counter; aborted instructions still retire, annulled ones do not
    always_ff @(posedge clk) begin
        if (nreset)
            instr_count <= '0;
        else if (state == S_WB && !annul_q)
            instr_count <= instr_count + CNT_W'(1);
    end

    // Strobe decode from state and latched flags only, never from mem_ready
    always_comb begin
        fetch_go           = 1'b0;
        regfetch_go        = 1'b0;
        execute_go         = 1'b0;
        mem_go             = 1'b0;
        wb_go              = 1'b0;
        mem_enable         = 1'b0;
        mem_read_not_write = 1'b0;
        reg_write          = 1'b0;
        pc_write           = 1'b0;
        pc_sel_branch      = 1'b0;
        halted             = 1'b0;
        case (state)
            S_IF:  fetch_go = 1'b1;
            S_RF:  regfetch_go = 1'b1;
            S_EX:  execute_go = 1'b1;
            S_MEM: begin
                mem_go             = 1'b1;
                mem_enable         = 1'b1;
                mem_read_not_write = load_q;
            end
            S_WB: begin
                wb_go         = 1'b1;
                pc_write      = 1'b1;
                pc_sel_branch = branch_q & ~annul_q;
                reg_write     = wr_q & ~annul_q & ~(mem_q & ~load_q) & ~abort_q;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Testbench for stage_sequencer: table-driven per-cycle vectors with a scoreboard queue.
// Timeout scenarios run only when STAGE_SEQ_MEM_TIMEOUT_EN is defined.
module tb_stage_sequencer;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 15;

    localparam logic [6:0] F_NONE  = 7'b0000000;
    localparam logic [6:0] F_MEMRD = 7'b1100000;
    localparam logic [6:0] F_MEMWR = 7'b1000000;
    localparam logic [6:0] F_WBREG = 7'b0011000;
    localparam logic [6:0] F_WB    = 7'b0001000;
    localparam logic [6:0] F_WBBR  = 7'b0001100;
    localparam logic [6:0] F_HALT  = 7'b0000010;
    localparam logic [6:0] F_FAULT = 7'b0000001;

    logic clk = 1'b0;
    logic nreset, cond_pass, is_branch, is_mem, is_load, writes_rd, mem_ready, halt_req;
    logic fetch_go, regfetch_go, execute_go, mem_go, wb_go;
    logic mem_enable, mem_read_not_write, reg_write, pc_write, pc_sel_branch;
    logic [2:0] state;
    logic halted, mem_fault;
    logic [CNT_W-1:0] instr_count;

    typedef struct {
        logic rst, cp, br, mem, ld, wr, rdy, hr;
        logic [2:0] st;
        logic [6:0] fl;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    typedef struct {
        logic [2:0] st;
        logic [11:0] strb;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    vec_t table_q[$];
    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int model_cnt = 0;

    always #5 clk = ~clk;

    stage_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .nreset(nreset), .cond_pass(cond_pass), .is_branch(is_branch),
        .is_mem(is_mem), .is_load(is_load), .writes_rd(writes_rd), .mem_ready(mem_ready),
        .halt_req(halt_req), .fetch_go(fetch_go), .regfetch_go(regfetch_go),
        .execute_go(execute_go), .mem_go(mem_go), .wb_go(wb_go), .mem_enable(mem_enable),
        .mem_read_not_write(mem_read_not_write), .reg_write(reg_write), .pc_write(pc_write),
        .pc_sel_branch(pc_sel_branch), .state(state), .halted(halted), .mem_fault(mem_fault),
        .instr_count(instr_count)
    );

    function automatic vec_t mk(input logic rst, cp, br, mem, ld, wr, rdy, hr,
                                input logic [2:0] st, input logic [6:0] fl, input int cnt);
        vec_t v;
        v.rst = rst; v.cp = cp; v.br = br; v.mem = mem; v.ld = ld; v.wr = wr;
        v.rdy = rdy; v.hr = hr; v.st = st; v.fl = fl; v.cnt = cnt[CNT_W-1:0];
        return v;
    endfunction

    function automatic logic [4:0] goOf(input logic [2:0] s);
        logic [4:0] one;
        one = 5'b10000;
        return (s <= 3'd4) ? (one >> s) : 5'b00000;
    endfunction

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        nreset = v.rst; cond_pass = v.cp; is_branch = v.br; is_mem = v.mem;
        is_load = v.ld; writes_rd = v.wr; mem_ready = v.rdy; halt_req = v.hr;
        e.st = v.st;
        e.strb = {goOf(v.st), v.fl};
        e.cnt = v.cnt;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        logic [11:0] got;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue, required an entry");
            return;
        end
        e = exp_q.pop_front();
        got = {fetch_go, regfetch_go, execute_go, mem_go, wb_go, mem_enable,
               mem_read_not_write, reg_write, pc_write, pc_sel_branch, halted, mem_fault};
        if (state !== e.st) begin
            errors++;
            $display("[TB] FAIL state @%0t: got %0d required %0d", $time, state, e.st);
        end
        checks++;
        if (got !== e.strb) begin
            errors++;
            $display("[TB] FAIL strobes @%0t: got %b required %b", $time, got, e.strb);
        end
        checks++;
        if (instr_count !== e.cnt) begin
            errors++;
            $display("[TB] FAIL instr_count @%0t: got %0d required %0d", $time, instr_count, e.cnt);
        end
    endtask

    task automatic runTable();
        for (int i = 0; i < table_q.size(); i++) begin
            @(negedge clk);
            applyStimulus(table_q[i]);
            #1;
            checkOutput();
        end
        table_q.delete();
    endtask

    // ALU op, optional halt request in WB
    task automatic addAlu(input logic hr, input logic [6:0] f);
        table_q.push_back(mk(0,0,0,0,0,0,0,0, 3'd0, F_NONE | f, model_cnt));
        table_q.push_back(mk(0,1,0,0,0,1,0,0, 3'd1, F_NONE | f, model_cnt));
        table_q.push_back(mk(0,0,0,0,0,0,0,0, 3'd2, F_NONE | f, model_cnt));
        table_q.push_back(mk(0,0,0,0,0,0,0,hr, 3'd4, F_WBREG | f, model_cnt));
        model_cnt = (model_cnt + 1) % (1 << CNT_W);
    endtask

    // Load front half: IF, RF, EX
    task automatic addLoadHead();
        table_q.push_back(mk(0,0,0,0,0,0,0,0, 3'd0, F_NONE, model_cnt));
        table_q.push_back(mk(0,1,0,1,1,1,0,0, 3'd1, F_NONE, model_cnt));
        table_q.push_back(mk(0,0,0,0,0,0,0,0, 3'd2, F_NONE, model_cnt));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nreset = 1'b1; cond_pass = 0; is_branch = 0; is_mem = 0;
        is_load = 0; writes_rd = 0; mem_ready = 0; halt_req = 0;
        repeat (2) @(posedge clk);

        // Main vector table
        addAlu(1'b0, F_NONE);
        // Load with three stalled MEM cycles
        addLoadHead();
        for (int i = 0; i < 3; i++) table_q.push_back(mk(0,0,0,0,0,0,0,0, 3'd3, F_MEMRD, model_cnt));
        table_q.push_back(mk(0,0,0,0,0,0,1,0, 3'd3, F_MEMRD, model_cnt));
        table_q.push_back(mk(0,0,0,0,0,0,0,0, 3'd4, F_WBREG, model_cnt));
        model_cnt++;
        // Store, ready in first MEM cycle, no register write
        table_q.push_back(mk(0,0,0,0,0,0,0,0, 3'd0, F_NONE, model_cnt));
        table_q.push_back(mk(0,1,0,1,0,1,0,0, 3'd1, F_NONE, model_cnt));
        table_q.push_back(mk(0,0,0,0,0,0,0,0, 3'd2, F_NONE, model_cnt));
        table_q.push_back(mk(0,0,0,0,0,0,1,0, 3'd3, F_MEMWR, model_cnt));
        table_q.push_back(mk(0,0,0,0,0,0,0,0, 3'd4, F_WB, model_cnt));
        model_cnt++;
        // Annulled branch that would write Rd
        table_q.push_back(mk(0,0,0,0,0,0,0,0, 3'd0, F_NONE, model_cnt));
        table_q.push_back(mk(0,0,1,0,0,1,0,0, 3'd1, F_NONE, model_cnt));
        table_q.push_back(mk(0,0,0,0,0,0,0,0, 3'd4, F_WB, model_cnt));
        // Taken branch, stray mem_ready in EX ignored
        table_q.push_back(mk(0,0,0,0,0,0,0,0, 3'd0, F_NONE, model_cnt));
        table_q.push_back(mk(0,1,1,0,0,0,0,0, 3'd1, F_NONE, model_cnt));
        table_q.push_back(mk(0,0,0,0,0,0,1,0, 3'd2, F_NONE, model_cnt));
        table_q.push_back(mk(0,0,0,0,0,0,0,0, 3'd4, F_WBBR, model_cnt));
        model_cnt++;
        // Annulled load skips MEM
        table_q.push_back(mk(0,0,0,0,0,0,0,0, 3'd0, F_NONE, model_cnt));
        table_q.push_back(mk(0,0,0,1,1,1,0,0, 3'd1, F_NONE, model_cnt));
        table_q.push_back(mk(0,0,0,0,0,0,1,0, 3'd4, F_WB, model_cnt));
        runTable();

        // Halt after an ALU op, hold in HALT under random inputs, then reset
        addAlu(1'b1, F_NONE);
        for (int i = 0; i < 10; i++)
            table_q.push_back(mk(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                                 1'($urandom), 1'($urandom), 1'($urandom), 3'd5, F_HALT, model_cnt));
        table_q.push_back(mk(1,0,0,0,0,0,0,0, 3'd5, F_HALT, model_cnt));
        model_cnt = 0;
        runTable();

        // Reset in the middle of a MEM wait
        addAlu(1'b0, F_NONE);
        addLoadHead();
        table_q.push_back(mk(0,0,0,0,0,0,0,0, 3'd3, F_MEMRD, model_cnt));
        table_q.push_back(mk(1,0,0,0,0,0,0,0, 3'd3, F_MEMRD, model_cnt));
        model_cnt = 0;
        runTable();

        // Counter wrap: sixteen retires on a 4-bit counter return it to zero
        for (int k = 0; k < 16; k++) addAlu(1'b0, F_NONE);
        runTable();

`ifdef STAGE_SEQ_MEM_TIMEOUT_EN
        // Ready in the limit cycle completes normally
        addLoadHead();
        for (int i = 0; i < MEM_TIMEOUT; i++)
            table_q.push_back(mk(0,0,0,0,0,0,0,0, 3'd3, F_MEMRD, model_cnt));
        table_q.push_back(mk(0,0,0,0,0,0,1,0, 3'd3, F_MEMRD, model_cnt));
        table_q.push_back(mk(0,0,0,0,0,0,0,0, 3'd4, F_WBREG, model_cnt));
        model_cnt++;
        // Stall past the limit: abort, fault sticks into the next instruction
        addLoadHead();
        for (int i = 0; i <= MEM_TIMEOUT; i++)
            table_q.push_back(mk(0,0,0,0,0,0,0,0, 3'd3, F_MEMRD, model_cnt));
        table_q.push_back(mk(0,0,0,0,0,0,0,0, 3'd4, F_WB | F_FAULT, model_cnt));
        model_cnt++;
        addAlu(1'b0, F_FAULT);
        runTable();
`endif

        // Final idle fetch check
        @(negedge clk);
        applyStimulus(mk(0,0,0,0,0,0,0,0, 3'd0, F_NONE
`ifdef STAGE_SEQ_MEM_TIMEOUT_EN
                         | F_FAULT
`endif
                         , model_cnt));
        #1;
        checkOutput();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Multicycle control unit for the ARM datapath.
- Steps each instruction through fetch, register fetch, execute, data memory and writeback, emitting one-hot stage enables.
- Annuls instructions whose condition fails, skips the memory stage for non-memory instructions, and waits on a data-memory ready handshake.
- Drives PC update/branch select and register-file write enable; counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter
MEM_TIMEOUT, 15, max MEM wait cycles before abort (used only with optional feature)

Ports:
clk  in  1  system clock
nreset  in  1  reset; synchronous, active-high (despite name)
cond_pass  in  1  condition test result for current instruction; sampled in RF
is_branch  in  1  decoded branch flag; sampled in RF
is_mem  in  1  decoded load/store flag; sampled in RF
is_load  in  1  1=load, 0=store; sampled in RF
writes_rd  in  1  decoded instruction writes Rd; sampled in RF
mem_ready  in  1  data memory done; meaningful only in MEM
halt_req  in  1  stop after current instruction; sampled in WB
fetch_go  out  1  IF stage enable
regfetch_go  out  1  RF stage enable
execute_go  out  1  EX stage enable
mem_go  out  1  MEM stage enable
wb_go  out  1  WB stage enable
mem_enable  out  1  data memory access request
mem_read_not_write  out  1  1=read, 0=write; valid while mem_enable=1
reg_write  out  1  register-file write enable
pc_write  out  1  PC update strobe
pc_sel_branch  out  1  1=PC takes branch target, 0=PC+4; valid with pc_write
state  out  3  current state, for debug ports
halted  out  1  in HALT state
mem_fault  out  1  sticky memory-timeout flag
instr_count  out  CNT_W  retired (non-annulled) instruction count

Behaviour:
- States: IF=0, RF=1, EX=2, MEM=3, WB=4, HALT=5. Codes 6/7 go to IF next cycle with all outputs 0.
- Reset: on rising clk with nreset=1, all of the following, overriding any in-flight instruction or MEM wait:
  - state=IF; all outputs 0 except fetch_go=1 (combinational from state);
  - latched flags, annul, wait counter, instr_count and mem_fault cleared.
- Stage enables: exactly one *_go high per cycle, equal to current state; none high in HALT.
- IF -> RF unconditionally (instruction memory has 1-cycle latency).
- RF: latch is_branch, is_mem, is_load, writes_rd, and annul = ~cond_pass.
  - cond_pass=1 -> EX; cond_pass=0 -> WB (annulled).
- EX -> MEM if latched is_mem, else -> WB.
- MEM:
  - mem_enable=1; mem_read_not_write = latched is_load.
  - Stays in MEM while mem_ready=0; mem_ready=1 in any MEM cycle (including the first) -> WB next cycle.
  - mem_ready outside MEM is ignored.
- WB:
  - pc_write=1; pc_sel_branch = is_branch & ~annul.
  - reg_write = writes_rd & ~annul & ~(is_mem & ~is_load) & ~abort.
  - instr_count += 1 if ~annul; wraps 2^CNT_W-1 -> 0.
  - Next state: halt_req=1 -> HALT, else IF.
- HALT: all strobes 0, halted=1; left only by reset.
- All strobe outputs are combinational decodes of state plus latched flags; no output depends combinationally on mem_ready.
- Latency: ALU/branch 4 cycles; annulled 3 cycles; load/store 5+N cycles, N = MEM cycles with mem_ready=0.

Optional Feature:
STAGE_SEQ_MEM_TIMEOUT_EN
- Defined: a wait counter starts at 0 on MEM entry and increments each MEM cycle with mem_ready=0.
  - Counter reaching MEM_TIMEOUT in MEM -> WB next cycle with abort=1.
  - Abort suppresses reg_write; pc_write still fires; instruction still counted.
  - mem_fault set to 1, sticky until reset.
  - mem_ready=1 in the same cycle the counter hits MEM_TIMEOUT is a normal completion, no fault.
- Undefined: MEM waits indefinitely; mem_fault tied 0; no counter logic.

Test Plan:
- Reset then ALU op (cond_pass=1, writes_rd=1, is_mem=0): state 0,1,2,4,0; reg_write=1 and pc_write=1 only in cycle 4; instr_count=1.
- Load with mem_ready low 3 cycles then high: MEM held 4 cycles with mem_enable=1, mem_read_not_write=1; reg_write=1 in WB; total 8 cycles.
- Store (is_load=0, writes_rd=1), mem_ready=1 first MEM cycle: mem_read_not_write=0; reg_write=0 in WB; 5 cycles.
- Branch with cond_pass=0: sequence 0,1,4; pc_sel_branch=0, reg_write=0, instr_count unchanged. Same with cond_pass=1: pc_sel_branch=1.
- halt_req=1 in WB: state=5, halted=1, all strobes 0 for 10 cycles; nreset=1 pulse -> IF, instr_count=0. Reset asserted mid-MEM wait -> IF next cycle, mem_enable=0.
- With STAGE_SEQ_MEM_TIMEOUT_EN, MEM_TIMEOUT=15, mem_ready held 0: WB after 16 MEM cycles, reg_write=0, mem_fault=1 persisting into next instruction. instr_count=2^CNT_W-1 plus one retire -> 0.
